prewish_mask_arbiter: RTL and testbench

Shares the single blinky mentor input (strobe plus 8-bit mask) between several mask sources, e.g. the DIP-switch load path, the auto-cycling test-mask generator and a future debug port. Requesters post a mask and hold a level request. The arbiter grants one requester round-robin and emits exactly one single-cycle strobe with that mask toward the mentor. It then enforces a hold-off so successive masks cannot arrive back-to-back. It sits in the controller between the mask sources and the mentor's STB_I/DAT_I.

---
 rtl/prewish_pkg.sv | 19 +
 rtl/prewish_mask_arbiter_if.sv | 41 ++++
 rtl/prewish_rr_picker.sv | 30 +++
 rtl/prewish_mask_arbiter.sv | 108 ++++++++++
 tb/tb_prewish_mask_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prewish_pkg.sv
// Shared definitions for the prewish mask path (arbiter, mentor, blinky).
package prewish_pkg;

    // Width of one blinky mask; the mentor and blinky use the same constant.
    localparam int unsigned PREWISH_MASK_W = 8;

    // Arbiter FSM states; the encodings are shared with other blocks.
    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StStrobe  = 2'b01,
        StHoldoff = 2'b10
    } prewish_state_e;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned prewish_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prewish_mask_arbiter_if.sv
// Bundle between the mask sources and the arbiter, plus the arbiter outputs.
interface prewish_mask_arbiter_if
    import prewish_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DAT_WIDTH = PREWISH_MASK_W
);

    localparam int unsigned GNT_W = prewish_idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]           REQ_I;
    logic [NUM_REQ*DAT_WIDTH-1:0] DAT_I;
    logic                         STB_O;
    logic [DAT_WIDTH-1:0]         DAT_O;
    logic [NUM_REQ-1:0]           ACK_O;
    logic [GNT_W-1:0]             GNT_O;
    logic                         BUSY_O;

    // Arbiter side.
    modport slave (
        input  REQ_I,
        input  DAT_I,
        output STB_O,
        output DAT_O,
        output ACK_O,
        output GNT_O,
        output BUSY_O
    );

    // Requester / observer side.
    modport master (
        output REQ_I,
        output DAT_I,
        input  STB_O,
        input  DAT_O,
        input  ACK_O,
        input  GNT_O,
        input  BUSY_O
    );

endinterface

// File: rtl/prewish_rr_picker.sv
// Combinational round-robin search: first set request after the last grant.
module prewish_rr_picker
    import prewish_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = prewish_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [31:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int off = int'(NUM_REQ); off >= 1; off--) begin
            cand = (32'(last) + 32'(off)) % NUM_REQ;
            if (req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/prewish_mask_arbiter.sv
// Round-robin arbiter feeding single-cycle mask strobes to the blinky mentor,
// with a fixed hold-off after every strobe.
module prewish_mask_arbiter
    import prewish_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DAT_WIDTH      = PREWISH_MASK_W,
    // Must be at least 1; a zero hold-off could re-grant a requester whose
    // REQ has not yet dropped.
    parameter int unsigned HOLDOFF_CYCLES = 16
) (
    input logic                   CLK_I,
    input logic                   RST_I,
    prewish_mask_arbiter_if.slave bus
);

    localparam int unsigned GNT_W = prewish_idx_w(NUM_REQ);
    localparam int unsigned CNT_W = prewish_idx_w(HOLDOFF_CYCLES);

    localparam logic [GNT_W-1:0] LAST_RST = GNT_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    prewish_state_e       state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [GNT_W-1:0]     last_q;
    logic                 stb_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [DAT_WIDTH-1:0] dat_q;
    logic [GNT_W-1:0]     gnt_q;
    logic                 busy_q;

    logic                 pick_found;
    logic [GNT_W-1:0]     pick_idx;
    logic [DAT_WIDTH-1:0] pick_dat;
    logic [NUM_REQ-1:0]   pick_onehot;

    prewish_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (bus.REQ_I),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_dat    = bus.DAT_I[32'(pick_idx) * DAT_WIDTH +: DAT_WIDTH];
    assign pick_onehot = {{(NUM_REQ - 1){1'b0}}, 1'b1} << pick_idx;

    // FSM, hold-off counter and all registered outputs.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            stb_q   <= 1'b0;
            ack_q   <= '0;
            dat_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    stb_q  <= 1'b0;
                    ack_q  <= '0;
                    busy_q <= 1'b0;
                    if (pick_found) begin
                        state_q <= StStrobe;
                        stb_q   <= 1'b1;
                        ack_q   <= pick_onehot;
                        dat_q   <= pick_dat;
                        gnt_q   <= pick_idx;
                        last_q  <= pick_idx;
                        busy_q  <= 1'b1;
                    end
                end
                StStrobe: begin
                    state_q <= StHoldoff;
                    stb_q   <= 1'b0;
                    ack_q   <= '0;
                    cnt_q   <= CNT_LOAD;
                    busy_q  <= 1'b1;
                end
                StHoldoff: begin
                    // Requests are ignored here; they are re-evaluated in idle.
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    stb_q   <= 1'b0;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.STB_O  = stb_q;
    assign bus.ACK_O  = ack_q;
    assign bus.DAT_O  = dat_q;
    assign bus.GNT_O  = gnt_q;
    assign bus.BUSY_O = busy_q;

endmodule

// File: tb/tb_prewish_mask_arbiter.sv
// Bench for prewish_mask_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the arbiter.
module tb_prewish_mask_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int H  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    prewish_mask_arbiter_if #(.NUM_REQ(NR), .DAT_WIDTH(DW)) bus ();

    prewish_mask_arbiter #(
        .NUM_REQ        (NR),
        .DAT_WIDTH      (DW),
        .HOLDOFF_CYCLES (H)
    ) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model state: m_left counts the busy cycles still to come, including
    // the current one (strobe cycle plus H hold-off cycles).
    bit         m_stb;
    bit [3:0]   m_ack;
    bit [7:0]   m_dat;
    bit [1:0]   m_gnt;
    bit         m_busy;
    int         m_left;
    int         m_last;

    task automatic model_step();
        bit hit;
        int k;
        if (rst) begin
            m_stb = 0; m_ack = 0; m_dat = 0; m_gnt = 0; m_busy = 0;
            m_left = 0; m_last = NR - 1;
        end else if (m_left > 0) begin
            m_left--;
            m_stb  = 0;
            m_ack  = 0;
            m_busy = (m_left > 0);
        end else begin
            m_stb = 0; m_ack = 0; m_busy = 0;
            hit = 0;
            for (int off = 1; off <= NR; off++) begin
                k = (m_last + off) % NR;
                if (!hit && bus.REQ_I[k]) begin
                    hit    = 1;
                    m_stb  = 1;
                    m_ack  = 4'b0001 << k;
                    m_dat  = bus.DAT_I[k*DW +: DW];
                    m_gnt  = 2'(k);
                    m_last = k;
                    m_busy = 1;
                    m_left = H + 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [15:0] out_now();
        return {bus.STB_O, bus.ACK_O, bus.DAT_O, bus.GNT_O, bus.BUSY_O};
    endfunction

    function automatic logic [15:0] out_model();
        return {m_stb, m_ack, m_dat, m_gnt, m_busy};
    endfunction

    task automatic test_reset();
        logic [7:0] d0;
        rst = 1'b1;
        bus.REQ_I = 4'b1111;
        bus.DAT_I = $urandom;
        d0 = bus.DAT_I[7:0];
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (out_now() !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got %h, want 0000", i, out_now());
            end
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({bus.STB_O, bus.ACK_O, bus.GNT_O, bus.DAT_O} !== {1'b1, 4'b0001, 2'd0, d0}) begin
            miscompares++;
            $display("FAIL reset_first_grant: got stb=%b ack=%b gnt=%0d dat=%h, want 1 0001 0 %h",
                     bus.STB_O, bus.ACK_O, bus.GNT_O, bus.DAT_O, d0);
        end
        bus.REQ_I = 4'b0000;
        for (int i = 0; i < H + 1; i++) begin
            tick();
            vectors++;
            if (out_now() !== out_model()) begin
                miscompares++;
                $display("FAIL reset_drain[%0d]: got %h, want %h", i, out_now(), out_model());
            end
        end
    endtask

    task automatic test_single();
        int pulses = 0;
        int busy_cyc = 0;
        bus.DAT_I[2*DW +: DW] = 8'hA8;
        bus.REQ_I = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (out_now() !== out_model()) begin
                miscompares++;
                $display("FAIL single_model[%0d]: got %h, want %h", i, out_now(), out_model());
            end
            if (i == 0) begin
                vectors++;
                if ({bus.STB_O, bus.ACK_O, bus.DAT_O, bus.GNT_O} !== {1'b1, 4'b0100, 8'hA8, 2'd2})
                begin
                    miscompares++;
                    $display("FAIL single_strobe: got stb=%b ack=%b dat=%h gnt=%0d, want 1 0100 a8 2",
                             bus.STB_O, bus.ACK_O, bus.DAT_O, bus.GNT_O);
                end
                bus.REQ_I = 4'b0000;
            end
            pulses   += int'(bus.STB_O);
            busy_cyc += int'(bus.BUSY_O);
        end
        vectors++;
        if (pulses != 1 || busy_cyc != H + 1) begin
            miscompares++;
            $display("FAIL single_counts: got pulses=%0d busy=%0d, want 1 %0d",
                     pulses, busy_cyc, H + 1);
        end
    endtask

    task automatic test_round_robin();
        int order[6];
        int when[6];
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        int rerise[4] = '{0, 0, 0, 0};
        int n = 0;
        rst = 1'b1;
        bus.REQ_I = 4'b0000;
        tick();
        vectors++;
        if (out_now() !== 16'h0000) begin
            miscompares++;
            $display("FAIL rr_reset: got %h, want 0000", out_now());
        end
        rst = 1'b0;
        bus.REQ_I = 4'b1111;
        bus.DAT_I = $urandom;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            tick();
            vectors++;
            if (out_now() !== out_model()) begin
                miscompares++;
                $display("FAIL rr_model[%0d]: got %h, want %h", cyc, out_now(), out_model());
            end
            if (bus.STB_O) begin
                order[n] = int'(bus.GNT_O);
                when[n]  = cyc;
                n++;
            end
            for (int k = 0; k < NR; k++) begin
                if (rerise[k] != 0) begin
                    bus.REQ_I[k] = 1'b1;
                    rerise[k] = 0;
                end
                if (m_ack[k]) begin
                    bus.REQ_I[k] = 1'b0;
                    rerise[k] = 1;
                end
            end
        end
        vectors++;
        if (n != 6) begin
            miscompares++;
            $display("FAIL rr_timeout: got %0d grants, want 6", n);
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (order[i] != exp_order[i]) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got %0d, want %0d", i, order[i], exp_order[i]);
            end
            if (i > 0) begin
                vectors++;
                if (when[i] - when[i-1] != H + 2) begin
                    miscompares++;
                    $display("FAIL rr_spacing[%0d]: got %0d, want %0d",
                             i, when[i] - when[i-1], H + 2);
                end
            end
        end
        bus.REQ_I = 4'b0000;
        for (int i = 0; i < H + 1; i++) begin
            tick();
            vectors++;
            if (out_now() !== out_model()) begin
                miscompares++;
                $display("FAIL rr_drain[%0d]: got %h, want %h", i, out_now(), out_model());
            end
        end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] reqs[4] = '{4'b1000, 4'b1010, 4'b1000, 4'b0001};
        int         exp_g[4] = '{3, 1, 3, 0};
        logic [3:0] exp_ack;
        for (int t = 0; t < 4; t++) begin
            bus.REQ_I = reqs[t];
            bus.DAT_I = $urandom;
            exp_ack = 4'b0001 << exp_g[t];
            tick();
            vectors++;
            if ({bus.STB_O, bus.ACK_O, bus.GNT_O} !== {1'b1, exp_ack, 2'(exp_g[t])}) begin
                miscompares++;
                $display("FAIL wrap_grant[%0d]: got stb=%b ack=%b gnt=%0d, want 1 %b %0d",
                         t, bus.STB_O, bus.ACK_O, bus.GNT_O, exp_ack, exp_g[t]);
            end
            bus.REQ_I = 4'b0000;
            for (int i = 0; i < H + 1; i++) begin
                tick();
                vectors++;
                if (out_now() !== out_model()) begin
                    miscompares++;
                    $display("FAIL wrap_model[%0d/%0d]: got %h, want %h",
                             t, i, out_now(), out_model());
                end
            end
        end
    endtask

    task automatic test_holdoff_req();
        int seen = -1;
        bus.DAT_I = 32'h0012_3456;
        bus.REQ_I = 4'b0001;
        tick();
        vectors++;
        if ({bus.STB_O, bus.GNT_O} !== {1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL hold_first: got stb=%b gnt=%0d, want 1 0", bus.STB_O, bus.GNT_O);
        end
        bus.REQ_I = 4'b0000;
        tick();
        bus.DAT_I[3*DW +: DW] = 8'hFF;
        bus.REQ_I = 4'b1000;
        for (int i = 2; i < 14 && seen < 0; i++) begin
            tick();
            vectors++;
            if (out_now() !== out_model()) begin
                miscompares++;
                $display("FAIL hold_model[%0d]: got %h, want %h", i, out_now(), out_model());
            end
            if (bus.STB_O) seen = i;
        end
        vectors++;
        if (seen != H + 2 || bus.DAT_O !== 8'hFF || bus.GNT_O !== 2'd3) begin
            miscompares++;
            $display("FAIL hold_second: got cycle=%0d dat=%h gnt=%0d, want %0d ff 3",
                     seen, bus.DAT_O, bus.GNT_O, H + 2);
        end
        bus.REQ_I = 4'b0000;
        for (int i = 0; i < H + 1; i++) begin
            tick();
            vectors++;
            if (out_now() !== out_model()) begin
                miscompares++;
                $display("FAIL hold_drain[%0d]: got %h, want %h", i, out_now(), out_model());
            end
        end
    endtask

    task automatic test_mid_reset();
        bus.DAT_I = 32'h0000_5C11;
        bus.REQ_I = 4'b0001;
        tick();
        bus.REQ_I = 4'b0010;
        tick();
        tick();
        vectors++;
        if (bus.BUSY_O !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_busy: got %b, want 1", bus.BUSY_O);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (out_now() !== 16'h0000) begin
            miscompares++;
            $display("FAIL midrst_clear: got %h, want 0000", out_now());
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({bus.STB_O, bus.ACK_O, bus.DAT_O, bus.GNT_O} !== {1'b1, 4'b0010, 8'h5C, 2'd1}) begin
            miscompares++;
            $display("FAIL midrst_regrant: got stb=%b ack=%b dat=%h gnt=%0d, want 1 0010 5c 1",
                     bus.STB_O, bus.ACK_O, bus.DAT_O, bus.GNT_O);
        end
        bus.REQ_I = 4'b0000;
        for (int i = 0; i < H + 1; i++) begin
            tick();
            vectors++;
            if (out_now() !== out_model()) begin
                miscompares++;
                $display("FAIL midrst_drain[%0d]: got %h, want %h", i, out_now(), out_model());
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            vectors++;
            if (out_now() !== out_model()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h, want %h", cyc, out_now(), out_model());
            end
            for (int k = 0; k < NR; k++) begin
                if (m_ack[k]) begin
                    bus.REQ_I[k] = 1'b0;
                end else if (!bus.REQ_I[k]) begin
                    if ($urandom_range(3) == 0) begin
                        // Frequent repeats of one mask exercise back-to-back equal masks.
                        bus.DAT_I[k*DW +: DW] = ($urandom_range(1) == 0) ? 8'h3C : 8'($urandom);
                        bus.REQ_I[k] = 1'b1;
                    end
                end else if ($urandom_range(31) == 0) begin
                    bus.REQ_I[k] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        bus.REQ_I = '0;
        bus.DAT_I = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_holdoff_req();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
